// File: rtl/dm_bus_bridge.sv
// Purpose: M-stage data-memory sequencer. It latches one load/store, runs a req/ack access on the memory bus and returns the extended load data.
// Latency: at least 3 cycles per access (IDLE, REQ, DONE). REQ lasts until bus_ack, or ends after TIMEOUT cycles.
// Backpressure: stall holds the pipeline frozen from the IDLE cycle until DONE. bus_req stays high until bus_ack or timeout.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   m_valid/m_addr/m_wdata/byteen/loadType - M-stage access request (byteen!=0 store, loadType!=0 load)
//   stall                 - combinational freeze of PC/F/D/E/M
//   ld_valid/ld_data/err  - DONE-cycle results (ld_valid and err are 1-cycle pulses)
//   bus_req/bus_we/bus_addr/bus_wdata/bus_be/bus_ack/bus_rdata - data-memory handshake
module dm_bus_bridge #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  byteen,
    input  logic [4:0]  loadType,
    output logic        stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [1:0]  off_q;
    logic [4:0]  lt_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic [3:0]  bus_be_q;
    logic        ld_valid_q;
    logic        err_q;
    logic [31:0] ld_data_q;

    logic        access_d;
    logic        is_store_d;
    logic        word_d;
    logic        half_d;
    logic        misalign_d;
    logic [31:0] wdata_al_d;
    logic [31:0] rsh_d;
    logic [15:0] half_sel_d;
    logic [31:0] ext_d;

    assign access_d   = m_valid && ((byteen != 4'b0000) || (loadType != 5'b00000));
    assign is_store_d = (byteen != 4'b0000);

    // Stores carry their width only in byteen (already shifted by offset), so a
    // halfword store at an odd address appears as 0110.
    assign word_d = is_store_d ? (byteen == 4'b1111) : loadType[0];
    assign half_d = is_store_d ? ((byteen == 4'b0011) || (byteen == 4'b0110) || (byteen == 4'b1100))
                               : (loadType[2] | loadType[1]);
    assign misalign_d = (word_d && (m_addr[1:0] != 2'b00)) || (half_d && m_addr[0]);

    assign wdata_al_d = (byteen == 4'b1111) ? m_wdata : (m_wdata << {m_addr[1:0], 3'b000});

    // Load extraction works on the latched offset and type, so it is valid while bus_ack is high in REQ.
    always_comb begin
        rsh_d      = bus_rdata >> {off_q, 3'b000};
        half_sel_d = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        ext_d      = bus_rdata;
        if (lt_q[4])      ext_d = {{24{rsh_d[7]}}, rsh_d[7:0]};
        else if (lt_q[3]) ext_d = {24'h000000, rsh_d[7:0]};
        else if (lt_q[2]) ext_d = {{16{half_sel_d[15]}}, half_sel_d};
        else if (lt_q[1]) ext_d = {16'h0000, half_sel_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            off_q       <= 2'b00;
            lt_q        <= 5'b00000;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_be_q    <= 4'b0000;
            ld_valid_q  <= 1'b0;
            err_q       <= 1'b0;
            ld_data_q   <= 32'h0;
        end else begin
            // err_q doubles as the error flag: it is only ever set on entry to DONE,
            // so the default clear here is the clear-on-exit from DONE.
            ld_valid_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (access_d) begin
                        off_q       <= m_addr[1:0];
                        lt_q        <= is_store_d ? 5'b00000 : loadType;
                        bus_addr_q  <= {m_addr[31:2], 2'b00};
                        bus_we_q    <= is_store_d;
                        bus_be_q    <= is_store_d ? byteen : 4'b1111;
                        bus_wdata_q <= wdata_al_d;
                        cnt_q       <= 8'd0;
                        if (misalign_d) begin
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            bus_req_q <= 1'b1;
                            state_q   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // ack has priority over the timeout in the same cycle
                    if (bus_ack) begin
                        bus_req_q <= 1'b0;
                        state_q   <= S_DONE;
                        if (lt_q != 5'b00000) begin
                            ld_data_q  <= ext_d;
                            ld_valid_q <= 1'b1;
                        end
                    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                        bus_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_DONE: begin
                    cnt_q   <= 8'd0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stall     = !reset && access_d && (state_q != S_DONE);
    assign ld_valid  = ld_valid_q;
    assign err       = err_q;
    // Zeroed during an error DONE. Otherwise the last good load result is held.
    assign ld_data   = err_q ? 32'h0 : ld_data_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;

endmodule

// File: doc/dm_bus_bridge.md
Name: dm_bus_bridge

Overview:
- M-stage memory access sequencer for the pipelined MIPS core.
- Consumes the memory-control outputs (byteen, loadType, aboutDM) plus the effective address and store data.
- Runs a req/ack handshake to the external data memory, stalls the pipeline for the duration of the access, and delivers the extended load value to the W stage.

Parameters:
TIMEOUT, 16, max cycles in REQ without bus_ack before abort (1..255)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
m_valid  input  1  M-stage instruction accesses DM (aboutDM)
m_addr  input  32  effective byte address
m_wdata  input  32  unshifted rt value for stores
byteen  input  4  store byte enables, already shifted by offset; 0 means load
loadType  input  5  one-hot {lb,lbu,lh,lhu,lw}; 0 for stores
stall  output  1  freeze PC/F/D/E/M registers
ld_valid  output  1  1-cycle pulse: ld_data holds a new load result
ld_data  output  32  extended load data
err  output  1  1-cycle pulse: misaligned access or bus timeout
bus_req  output  1  memory request
bus_we  output  1  1 = write
bus_addr  output  32  word-aligned address, {addr[31:2],2'b00}
bus_wdata  output  32  lane-aligned store data
bus_be  output  4  byte enables
bus_ack  input  1  memory completes request this cycle
bus_rdata  input  32  read word, valid when bus_ack=1

Behaviour:
- FSM states: IDLE, REQ, DONE. Reset forces IDLE. Reset also clears every output to 0 and clears all latched registers.
- IDLE:
  - If m_valid=0, or byteen=0 and loadType=0, no stall and stay in IDLE.
  - Otherwise stall=1. Latch addr[1:0], addr, byteen, loadType and aligned wdata.
  - If misaligned, go to DONE with an error flag set. Misaligned means: lw/sw with addr[1:0]≠0, or lh/lhu/sh with addr[0]≠0.
  - Else go to REQ.
- REQ:
  - bus_req=1; bus_addr, bus_we, bus_wdata and bus_be are driven from the latched values and held stable.
  - stall=1.
  - On bus_ack: capture bus_rdata and go to DONE.
  - Cycle counter starts at 0 on entry. If it reaches TIMEOUT without ack, drop bus_req, set the error flag, go to DONE.
  - An ack arriving in the same cycle as the timeout wins, with no error.
- DONE:
  - stall=0, so the pipeline advances at the end of this cycle.
  - For a load without error: ld_valid=1 and ld_data updated.
  - If the error flag is set: err=1 and ld_data=0.
  - Next state is always IDLE.
  - The counter and error flag clear on exit.
- stall is combinational: m_valid & (state≠DONE) & (byteen≠0 | loadType≠0). Every other output is registered or decoded from state and latched values.
- Minimum access is 3 cycles (IDLE, REQ with immediate ack, DONE). Back-to-back memory instructions each re-enter through IDLE.
- Store path:
  - bus_we=1, bus_be=latched byteen.
  - bus_wdata = m_wdata when byteen=1111; otherwise m_wdata << (8*addr[1:0]).
  - No ld_valid is produced for stores.
- Load path:
  - bus_we=0, bus_be=1111.
  - lb/lbu select byte off (bits 8*off+7..8*off), then sign- or zero-extend.
  - lh/lhu select the halfword at off[1], then sign- or zero-extend.
  - lw passes the word unchanged.
- ld_data holds its value until the next successful load.
- Reset while in REQ: bus_req=0 on the next edge. A late ack is ignored while in IDLE.
- bus_ack received outside REQ is ignored.

Test Plan:
- lw addr 0x0000_1004, ack in first REQ cycle, rdata 0xDEADBEEF -> req=1 one cycle, be=1111, we=0; DONE: ld_valid=1, ld_data=0xDEADBEEF; stall high exactly 2 cycles.
- lb addr 0x0000_2003, rdata 0x80FF_0000 -> ld_data=0xFFFF_FF80. Repeat as lbu -> 0x0000_0080. lh at offset 2 with rdata 0x8001_1234 -> 0xFFFF_8001.
- sh addr 0x0000_3002, m_wdata 0x0000_1234, byteen 1100 -> bus_be=1100, bus_wdata=0x1234_0000, we=1, bus_addr=0x0000_3000, ld_valid stays 0.
- sw with ack delayed 5 cycles -> bus_req and bus fields stable for 6 cycles, stall=1 throughout, drops in DONE. With TIMEOUT=4 and no ack -> req drops after 4 cycles, err=1 for 1 cycle.
- lw addr 0x0000_0002 -> bus_req never asserted, err=1 in DONE, ld_data=0, stall=1 for 1 cycle.
- reset asserted in REQ cycle 2, then ack arrives -> state IDLE, bus_req=0, no ld_valid, stall=0.
